// File: rtl/wb_timer_pkg.sv
// Shared register indices, CTRL bit positions and the byte-lane merge helper
// for the wb_timer Wishbone timer/compare peripheral.
package wb_timer_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_COMPARE  = 3'd2;
  localparam logic [2:0] ADDR_COUNT    = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_CAPTURE  = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQEN  = 2;
  localparam int CTRL_W      = 3;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler for wb_timer: counts 0..prescale while enabled and fires a tick
// in the cycle the counter equals prescale; held at 0 when disabled or cleared.
module wb_timer_prescaler
  import wb_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == prescale);

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: 32-bit Wishbone-classic timer with prescaler, one-shot or
// auto-reload compare, W1C pending flag and level irq. Define
// WB_TIMER_CAPTURE_EN to add the capture_i input and CAPTURE register.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int          PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
`ifdef WB_TIMER_CAPTURE_EN
  ,
  input  logic        capture_i
`endif
);

  logic [CTRL_W-1:0]     ctrl, ctrl_n;
  logic [PRESCALE_W-1:0] prescale, prescale_n;
  logic [31:0]           compare, compare_n;
  logic [31:0]           count, count_n;
  logic                  pending, pending_n;
  logic                  irq_n;
  logic [31:0]           rd_data;
  logic [31:0]           prescale_ext, prescale_wr;
  logic [2:0]            idx;
  logic                  access, wr, rd, status_wr, count_wr;
  logic                  tick, match;

  assign idx       = wb_adr_i[4:2];
  assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = access & wb_we_i;
  assign rd        = access & ~wb_we_i;
  assign status_wr = wr && (idx == ADDR_STATUS) && wb_sel_i[0];
  assign count_wr  = wr && (idx == ADDR_COUNT) && (|wb_sel_i);
  assign match     = tick && (count == compare);

  always_comb begin
    prescale_ext = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale;
  end
  assign prescale_wr = merge_bytes(prescale_ext, wb_dat_i, wb_sel_i);

  // Address bits outside [4:2] and high merge bits beyond PRESCALE_W are don't-care.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], prescale_wr};

  // A COUNT write restarts the prescale period so the new value gets a full tick.
  wb_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en       (ctrl[CTRL_EN]),
    .clr      (count_wr),
    .prescale (prescale),
    .tick     (tick)
  );

`ifdef WB_TIMER_CAPTURE_EN
  logic [2:0]  cap_sync;
  logic        cap_rise;
  logic [31:0] capture, capture_n;
  logic        cap_pending, cap_pending_n;

  // Two synchroniser stages plus one history flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cap_sync <= '0;
    else       cap_sync <= {cap_sync[1:0], capture_i};
  end
  assign cap_rise = cap_sync[1] & ~cap_sync[2];
`endif

  always_comb begin
    rd_data = '0;
    case (idx)
      ADDR_CTRL:     rd_data[CTRL_W-1:0] = ctrl;
      ADDR_PRESCALE: rd_data = prescale_ext;
      ADDR_COMPARE:  rd_data = compare;
      ADDR_COUNT:    rd_data = count;
      ADDR_STATUS: begin
        rd_data[0] = pending;
`ifdef WB_TIMER_CAPTURE_EN
        rd_data[1] = cap_pending;
`endif
      end
`ifdef WB_TIMER_CAPTURE_EN
      ADDR_CAPTURE:  rd_data = capture;
`endif
      default:       rd_data = '0;
    endcase
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    ctrl_n     = ctrl;
    prescale_n = prescale;
    compare_n  = compare;
    count_n    = count;

    if (tick) begin
      if (match) begin
        if (ctrl[CTRL_RELOAD]) count_n = '0;
        else                   ctrl_n[CTRL_EN] = 1'b0;
      end else begin
        count_n = count + 32'd1;
      end
    end

    // Software writes come after the timer update so they win any conflict.
    if (wr) begin
      case (idx)
        ADDR_CTRL:     if (wb_sel_i[0]) ctrl_n = wb_dat_i[CTRL_W-1:0];
        ADDR_PRESCALE: prescale_n = prescale_wr[PRESCALE_W-1:0];
        ADDR_COMPARE:  compare_n = merge_bytes(compare, wb_dat_i, wb_sel_i);
        ADDR_COUNT:    count_n = merge_bytes(count, wb_dat_i, wb_sel_i);
        default:       ;
      endcase
    end

    pending_n = match | (pending & ~(status_wr & wb_dat_i[0]));

`ifdef WB_TIMER_CAPTURE_EN
    capture_n     = cap_rise ? count : capture;
    cap_pending_n = cap_rise | (cap_pending & ~(status_wr & wb_dat_i[1]));
    irq_n         = (pending_n | cap_pending_n) & ctrl_n[CTRL_IRQEN];
`else
    irq_n         = pending_n & ctrl_n[CTRL_IRQEN];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= RESET_COMPARE;
      count    <= '0;
      pending  <= 1'b0;
      irq_o    <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ctrl     <= ctrl_n;
      prescale <= prescale_n;
      compare  <= compare_n;
      count    <= count_n;
      pending  <= pending_n;
      irq_o    <= irq_n;
      wb_ack_o <= access;
      wb_dat_o <= rd ? rd_data : '0;
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      capture     <= '0;
      cap_pending <= 1'b0;
    end else begin
      capture     <= capture_n;
      cap_pending <= cap_pending_n;
    end
  end
`endif

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register table, then cycle-exact
// sequences for auto-reload, one-shot, write conflicts and optional capture.
module tb_wb_timer;
  import wb_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_ack, irq;
`ifdef WB_TIMER_CAPTURE_EN
  logic        capture;
`endif

  int checks = 0;
  int errors = 0;

  wb_timer dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_cyc_i (wb_cyc),
    .wb_stb_i (wb_stb),
    .wb_we_i  (wb_we),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat_w),
    .wb_sel_i (wb_sel),
    .wb_dat_o (wb_dat_r),
    .wb_ack_o (wb_ack),
    .irq_o    (irq)
`ifdef WB_TIMER_CAPTURE_EN
    ,
    .capture_i(capture)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the second edge.
  task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] data,
                         input logic [3:0] sel, output logic [31:0] rdata);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = {27'd0, idx, 2'b00}; wb_dat_w = data; wb_sel = sel;
    @(posedge clk); #1;
    check("ack_one_cycle_after_strobe", {31'd0, wb_ack}, 32'd1);
    rdata = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check("ack_single_cycle", {31'd0, wb_ack}, 32'd0);
    check("dat_zero_without_ack", wb_dat_r, 32'd0);
  endtask

  task automatic wb_wr(input logic [2:0] idx, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, data, 4'hF, dummy);
  endtask

  task automatic wb_rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] rdata;
    wb_xfer(1'b0, idx, 32'd0, 4'hF, rdata);
    check(name, rdata, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rdata;

    vecs[0]  = '{1'b0, ADDR_CTRL,     32'h0,         4'hF, 32'h0000_0000};
    vecs[1]  = '{1'b0, ADDR_PRESCALE, 32'h0,         4'hF, 32'h0000_0000};
    vecs[2]  = '{1'b0, ADDR_COMPARE,  32'h0,         4'hF, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, ADDR_COUNT,    32'h0,         4'hF, 32'h0000_0000};
    vecs[4]  = '{1'b0, ADDR_STATUS,   32'h0,         4'hF, 32'h0000_0000};
    vecs[5]  = '{1'b0, 3'd5,          32'h0,         4'hF, 32'h0000_0000};
    vecs[6]  = '{1'b0, 3'd6,          32'h0,         4'hF, 32'h0000_0000};
    vecs[7]  = '{1'b0, 3'd7,          32'h0,         4'hF, 32'h0000_0000};
    vecs[8]  = '{1'b1, ADDR_COMPARE,  32'hAABB_CCDD, 4'b0010, 32'h0};
    vecs[9]  = '{1'b0, ADDR_COMPARE,  32'h0,         4'hF, 32'hFFFF_CCFF};
    vecs[10] = '{1'b1, ADDR_PRESCALE, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, ADDR_PRESCALE, 32'h0,         4'hF, 32'h0000_FFFF};
    vecs[12] = '{1'b1, ADDR_PRESCALE, 32'h1234_5678, 4'b0001, 32'h0};
    vecs[13] = '{1'b0, ADDR_PRESCALE, 32'h0,         4'hF, 32'h0000_FF78};
    vecs[14] = '{1'b1, ADDR_CTRL,     32'hFFFF_FFF2, 4'hF, 32'h0};
    vecs[15] = '{1'b0, ADDR_CTRL,     32'h0,         4'hF, 32'h0000_0002};
    vecs[16] = '{1'b1, ADDR_CTRL,     32'h0,         4'hF, 32'h0};
    vecs[17] = '{1'b1, ADDR_COUNT,    32'h1234_5678, 4'b1100, 32'h0};
    vecs[18] = '{1'b0, ADDR_COUNT,    32'h0,         4'hF, 32'h1234_0000};
    vecs[19] = '{1'b1, 3'd6,          32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[20] = '{1'b0, 3'd6,          32'h0,         4'hF, 32'h0000_0000};
    vecs[21] = '{1'b0, ADDR_COMPARE,  32'h0,         4'hF, 32'hFFFF_CCFF};
    vecs[22] = '{1'b1, ADDR_STATUS,   32'h1,         4'hF, 32'h0};
    vecs[23] = '{1'b0, ADDR_STATUS,   32'h0,         4'hF, 32'h0000_0000};
    vecs[24] = '{1'b1, ADDR_COUNT,    32'h0,         4'hF, 32'h0};
    vecs[25] = '{1'b1, ADDR_PRESCALE, 32'h0,         4'hF, 32'h0};
    vecs[26] = '{1'b0, ADDR_COUNT,    32'h0,         4'hF, 32'h0000_0000};

    rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
`ifdef WB_TIMER_CAPTURE_EN
    capture = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    check("reset_ack", {31'd0, wb_ack}, 32'd0);
    check("reset_dat", wb_dat_r, 32'd0);
    irq_chk("reset_irq", 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      wb_xfer(vecs[i].we, vecs[i].idx, vecs[i].data, vecs[i].sel, rdata);
      if (!vecs[i].we) check($sformatf("table_read_%0d", i), rdata, vecs[i].exp);
    end

    // Held strobe: ack every other cycle.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = {27'd0, ADDR_CTRL, 2'b00};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_strobe_ack_%0d", i), {31'd0, wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    wait_cycles(1);

    // Auto-reload: PRESCALE=3, COMPARE=4 -> match every 20 cycles.
    wb_wr(ADDR_PRESCALE, 32'd3);
    wb_wr(ADDR_COMPARE, 32'd4);
    wb_wr(ADDR_COUNT, 32'd0);
    wb_wr(ADDR_CTRL, 32'd7);
    for (int k = 0; k < 5; k++) begin
      wb_rd_chk($sformatf("ar_count_%0d", k), ADDR_COUNT, k);
      if (k < 4) wait_cycles(2);
    end
    irq_chk("ar_irq_before_match", 1'b0);
    wait_cycles(1);
    irq_chk("ar_irq_after_match", 1'b1);
    wb_rd_chk("ar_count_reloaded", ADDR_COUNT, 32'd0);
    wb_rd_chk("ar_status_pending", ADDR_STATUS, 32'd1);
    wb_wr(ADDR_STATUS, 32'd1);
    irq_chk("ar_irq_cleared", 1'b0);
    wb_rd_chk("ar_status_cleared", ADDR_STATUS, 32'd0);
    wait_cycles(11);
    irq_chk("ar_irq_before_second_match", 1'b0);
    wait_cycles(1);
    irq_chk("ar_irq_second_match", 1'b1);
    wb_wr(ADDR_CTRL, 32'd0);
    irq_chk("ar_irq_irqen_off", 1'b0);

    // One-shot: PRESCALE=0, COMPARE=10.
    wb_wr(ADDR_COUNT, 32'd0);
    wb_wr(ADDR_PRESCALE, 32'd0);
    wb_wr(ADDR_COMPARE, 32'd10);
    wb_wr(ADDR_STATUS, 32'd1);
    wb_wr(ADDR_CTRL, 32'd5);
    wait_cycles(9);
    irq_chk("os_irq_before_match", 1'b0);
    wait_cycles(1);
    irq_chk("os_irq_after_match", 1'b1);
    wait_cycles(5);
    wb_rd_chk("os_ctrl_en_cleared", ADDR_CTRL, 32'd4);
    wb_rd_chk("os_count_holds", ADDR_COUNT, 32'd10);
    wb_rd_chk("os_status", ADDR_STATUS, 32'd1);
    wait_cycles(5);
    wb_rd_chk("os_count_still_holds", ADDR_COUNT, 32'd10);

    // W1C coincident with a match: set wins.
    wb_wr(ADDR_CTRL, 32'd0);
    wb_wr(ADDR_COUNT, 32'd0);
    wb_wr(ADDR_COMPARE, 32'd5);
    wb_wr(ADDR_STATUS, 32'd1);
    wb_wr(ADDR_CTRL, 32'd3);
    wait_cycles(10);
    wb_wr(ADDR_STATUS, 32'd1);
    wb_rd_chk("w1c_on_match_pending_kept", ADDR_STATUS, 32'd1);
    wb_wr(ADDR_STATUS, 32'd1);
    wb_rd_chk("w1c_off_match_clears", ADDR_STATUS, 32'd0);
    wb_wr(ADDR_CTRL, 32'd0);

    // COUNT write coincident with a tick: software value wins.
    wb_wr(ADDR_COMPARE, 32'hFFFF_FFFF);
    wb_wr(ADDR_PRESCALE, 32'd3);
    wb_wr(ADDR_COUNT, 32'd0);
    wb_wr(ADDR_STATUS, 32'd1);
    wb_wr(ADDR_CTRL, 32'd1);
    wait_cycles(6);
    wb_wr(ADDR_COUNT, 32'h100);
    wb_rd_chk("count_write_on_tick", ADDR_COUNT, 32'h100);
    wait_cycles(1);
    wb_rd_chk("count_next_tick", ADDR_COUNT, 32'h101);
    wb_wr(ADDR_COUNT, 32'h200);
    wb_rd_chk("count_write_restarts_prescaler", ADDR_COUNT, 32'h200);
    wb_wr(ADDR_CTRL, 32'd0);

`ifdef WB_TIMER_CAPTURE_EN
    // Capture: edge seen at COUNT=7 lands COUNT=9 in CAPTURE.
    wb_wr(ADDR_COUNT, 32'd0);
    wb_wr(ADDR_PRESCALE, 32'd0);
    wb_wr(ADDR_STATUS, 32'd3);
    wb_wr(ADDR_CTRL, 32'd5);
    wait_cycles(6);
    capture = 1'b1;
    wait_cycles(2);
    irq_chk("cap_irq_before_capture", 1'b0);
    wait_cycles(1);
    irq_chk("cap_irq_after_capture", 1'b1);
    capture = 1'b0;
    wb_wr(ADDR_CTRL, 32'd4);
    wb_rd_chk("cap_value", ADDR_CAPTURE, 32'd9);
    wb_rd_chk("cap_status", ADDR_STATUS, 32'd2);
    wb_wr(ADDR_STATUS, 32'd2);
    wb_rd_chk("cap_status_cleared", ADDR_STATUS, 32'd0);
    irq_chk("cap_irq_cleared", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
